// File: rtl/mem_stage_pipelined.sv
// rtl/mem_stage_pipelined.sv - memory stage with data RAM, stalling loads and writeback pipeline registers
//
// Purpose: sits between execute and writeback. Stores are single-cycle;
// loads stall upstream for LAT wait cycles before being accepted. Accepted
// instructions are registered into the writeback fields; anything else
// becomes a bubble.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   valid_in, flush      instruction present / kill in-flight instruction
//   mem_we, mem_re       store / load request (store wins if both set)
//   size_word            1 = word access, 0 = byte access (bits [7:0])
//   load_signed          byte load sign-extension select
//   wb_from_mem          writeback select: load data vs alu_result
//   reg_we, reg_dst      register-file write enable and destination
//   alu_result           address (low ADDR_W bits) or ALU writeback value
//   store_data           store data
//   stall                combinational hold request to upstream
//   valid_out, reg_we_out, wb_data_out, reg_dst_out   registered writeback fields
module mem_stage_pipelined #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 14,
  parameter int REG_W  = 4,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              flush,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic              size_word,
  input  logic              load_signed,
  input  logic              wb_from_mem,
  input  logic              reg_we,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  reg_dst,
  output logic              stall,
  output logic              valid_out,
  output logic              reg_we_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [REG_W-1:0]  reg_dst_out
);

  // A LAT=0 build never leaves IDLE, but keep a 1-bit counter so the
  // datapath stays legal.
  localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LAT > 0) ? CNT_W'(LAT - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_out_q, valid_out_d;
  logic               reg_we_out_q, reg_we_out_d;
  logic [DATA_W-1:0]  wb_data_out_q, wb_data_out_d;
  logic [REG_W-1:0]   reg_dst_out_q, reg_dst_out_d;

  logic [DATA_W-1:0]  mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  entry;
  logic [DATA_W-1:0]  load_data;
  logic [DATA_W-1:0]  wb_data;
  logic               is_load;
  logic               accept;
  logic               mem_wr;

  assign addr  = alu_result[ADDR_W-1:0];
  assign entry = mem[addr];

  // Byte loads take bits [7:0] and fill the rest with zero or bit 7.
  always_comb begin
    load_data = entry;
    if (!size_word) begin
      for (int i = 8; i < DATA_W; i++) begin
        load_data[i] = load_signed & entry[7];
      end
    end
  end

  assign wb_data = wb_from_mem ? load_data : alu_result;

  // Next-state, stall and acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    is_load = valid_in & mem_re & ~mem_we;

    case (state_q)
      IDLE: begin
        if ((LAT > 0) && is_load) begin
          stall   = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Final wait cycle: the load is accepted on this edge.
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Upstream must see no stall while the stage is being reset.
    if (reset) begin
      stall = 1'b0;
    end

    // Flush abandons any pending load and beats acceptance.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    accept = valid_in & ~stall & ~flush;
  end

  assign mem_wr = accept & mem_we & ~reset;

  // Accepted instructions fill the writeback fields; otherwise a bubble
  // clears the valid/enable bits and the data fields hold.
  always_comb begin
    valid_out_d   = accept;
    reg_we_out_d  = accept & reg_we;
    wb_data_out_d = wb_data_out_q;
    reg_dst_out_d = reg_dst_out_q;
    if (accept) begin
      wb_data_out_d = wb_data;
      reg_dst_out_d = reg_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      valid_out_q   <= 1'b0;
      reg_we_out_q  <= 1'b0;
      wb_data_out_q <= '0;
      reg_dst_out_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      valid_out_q   <= valid_out_d;
      reg_we_out_q  <= reg_we_out_d;
      wb_data_out_q <= wb_data_out_d;
      reg_dst_out_q <= reg_dst_out_d;
    end
  end

  // Memory contents survive reset and flush; byte stores leave the upper bits alone.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      if (size_word) begin
        mem[addr] <= store_data;
      end else begin
        mem[addr][7:0] <= store_data[7:0];
      end
    end
  end

  assign valid_out   = valid_out_q;
  assign reg_we_out  = reg_we_out_q;
  assign wb_data_out = wb_data_out_q;
  assign reg_dst_out = reg_dst_out_q;

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// tb/tb_mem_stage_pipelined.sv - directed self-checking bench for mem_stage_pipelined
module tb_mem_stage_pipelined;

  logic        clk;
  logic        reset;

  logic        valid_in, flush, mem_we, mem_re, size_word, load_signed, wb_from_mem, reg_we;
  logic [23:0] alu_result, store_data;
  logic [3:0]  reg_dst;
  logic        stall, valid_out, reg_we_out;
  logic [23:0] wb_data_out;
  logic [3:0]  reg_dst_out;

  logic        b_valid_in, b_flush, b_mem_we, b_mem_re, b_size_word, b_load_signed, b_wb_from_mem, b_reg_we;
  logic [23:0] b_alu_result, b_store_data;
  logic [3:0]  b_reg_dst;
  logic        b_stall, b_valid_out, b_reg_we_out;
  logic [23:0] b_wb_data_out;
  logic [3:0]  b_reg_dst_out;

  int n_checks;
  int n_fail;

  mem_stage_pipelined #(.DATA_W(24), .ADDR_W(14), .REG_W(4), .LAT(2)) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
    .mem_we(mem_we), .mem_re(mem_re), .size_word(size_word),
    .load_signed(load_signed), .wb_from_mem(wb_from_mem), .reg_we(reg_we),
    .alu_result(alu_result), .store_data(store_data), .reg_dst(reg_dst),
    .stall(stall), .valid_out(valid_out), .reg_we_out(reg_we_out),
    .wb_data_out(wb_data_out), .reg_dst_out(reg_dst_out)
  );

  mem_stage_pipelined #(.DATA_W(24), .ADDR_W(14), .REG_W(4), .LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .valid_in(b_valid_in), .flush(b_flush),
    .mem_we(b_mem_we), .mem_re(b_mem_re), .size_word(b_size_word),
    .load_signed(b_load_signed), .wb_from_mem(b_wb_from_mem), .reg_we(b_reg_we),
    .alu_result(b_alu_result), .store_data(b_store_data), .reg_dst(b_reg_dst),
    .stall(b_stall), .valid_out(b_valid_out), .reg_we_out(b_reg_we_out),
    .wb_data_out(b_wb_data_out), .reg_dst_out(b_reg_dst_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_a();
    valid_in = 0; flush = 0; mem_we = 0; mem_re = 0; size_word = 1;
    load_signed = 0; wb_from_mem = 0; reg_we = 0;
    alu_result = '0; store_data = '0; reg_dst = '0;
  endtask

  task automatic store_a(input logic [23:0] a, input logic [23:0] d, input logic word);
    idle_a();
    valid_in = 1; mem_we = 1; size_word = word; alu_result = a; store_data = d;
    tick();
  endtask

  // Load with LAT=2: two stall cycles, result visible after the third edge.
  task automatic load_a(input string tag, input logic [23:0] a, input logic word,
                        input logic sgn, input logic [23:0] exp);
    idle_a();
    valid_in = 1; mem_re = 1; size_word = word; load_signed = sgn;
    wb_from_mem = 1; reg_we = 1; alu_result = a; reg_dst = 4'd6;
    tick();
    tick();
    tick();
    chk({tag, "_valid"}, valid_out, 1);
    chk(tag, wb_data_out, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset cycle with a load presented: stall must stay low.
    reset = 1;
    idle_a();
    valid_in = 1; mem_re = 1;
    b_valid_in = 0; b_flush = 0; b_mem_we = 0; b_mem_re = 0; b_size_word = 1;
    b_load_signed = 0; b_wb_from_mem = 0; b_reg_we = 0;
    b_alu_result = '0; b_store_data = '0; b_reg_dst = '0;
    #1;
    chk("stall_in_reset", stall, 0);
    tick();
    tick();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_reg_we_out", reg_we_out, 0);
    chk("rst_wb_data", wb_data_out, 0);
    chk("rst_reg_dst", reg_dst_out, 0);
    chk("rst_b_valid_out", b_valid_out, 0);

    // ALU op completes after one edge.
    reset = 0;
    idle_a();
    valid_in = 1; alu_result = 24'h00ABCD; reg_dst = 4'd3; reg_we = 1;
    #1;
    chk("alu_stall", stall, 0);
    tick();
    chk("alu_valid", valid_out, 1);
    chk("alu_reg_we", reg_we_out, 1);
    chk("alu_wb", wb_data_out, 24'h00ABCD);
    chk("alu_dst", reg_dst_out, 3);

    // Bubble: valid/enable drop, data holds.
    idle_a();
    tick();
    chk("bubble_valid", valid_out, 0);
    chk("bubble_reg_we", reg_we_out, 0);
    chk("bubble_wb_hold", wb_data_out, 24'h00ABCD);
    chk("bubble_dst_hold", reg_dst_out, 3);

    // Word store: single cycle, no register write.
    store_a(24'd5, 24'h123456, 1);
    chk("store_valid", valid_out, 1);
    chk("store_reg_we", reg_we_out, 0);

    // Word load from 5: stall exactly two cycles.
    idle_a();
    valid_in = 1; mem_re = 1; wb_from_mem = 1; reg_we = 1; reg_dst = 4'd9; alu_result = 24'd5;
    #1;
    chk("ld_stall_c0", stall, 1);
    tick();
    chk("ld_stall_c1", stall, 1);
    chk("ld_valid_c1", valid_out, 0);
    tick();
    chk("ld_stall_c2", stall, 0);
    chk("ld_valid_c2", valid_out, 0);
    tick();
    chk("ld_valid", valid_out, 1);
    chk("ld_reg_we", reg_we_out, 1);
    chk("ld_wb", wb_data_out, 24'h123456);
    chk("ld_dst", reg_dst_out, 9);

    // Back-to-back load re-enters IDLE and stalls again.
    #0;
    chk("b2b_stall", stall, 1);

    // Byte store into a word holding 0xFFFF00.
    store_a(24'd7, 24'hFFFF00, 1);
    store_a(24'd7, 24'hAAAA80, 0);
    load_a("byte_signed", 24'd7, 0, 1, 24'hFFFF80);
    load_a("byte_unsigned", 24'd7, 0, 0, 24'h000080);
    load_a("byte_store_word", 24'd7, 1, 0, 24'hFFFF80);

    // Positive byte sign-extends with zeros.
    store_a(24'd8, 24'h33337F, 1);
    load_a("byte_signed_pos", 24'd8, 0, 1, 24'h00007F);

    // Address wraps: 0x4005 reads entry 5.
    load_a("addr_wrap", 24'h004005, 1, 0, 24'h123456);

    // mem_we and mem_re together: a store, no stall.
    idle_a();
    valid_in = 1; mem_we = 1; mem_re = 1; alu_result = 24'd20; store_data = 24'h0A0B0C;
    #1;
    chk("we_re_stall", stall, 0);
    tick();
    chk("we_re_valid", valid_out, 1);
    load_a("we_re_ld", 24'd20, 1, 0, 24'h0A0B0C);

    // Flushed store does not write memory.
    idle_a();
    valid_in = 1; mem_we = 1; flush = 1; alu_result = 24'd5; store_data = 24'h999999;
    tick();
    chk("flush_st_valid", valid_out, 0);
    load_a("flush_st_ld", 24'd5, 1, 0, 24'h123456);

    // Flush in the second WAIT cycle abandons the load.
    idle_a();
    valid_in = 1; mem_re = 1; wb_from_mem = 1; reg_we = 1; reg_dst = 4'd12; alu_result = 24'd7;
    tick();
    tick();
    flush = 1;
    tick();
    chk("flush_ld_valid", valid_out, 0);
    chk("flush_ld_reg_we", reg_we_out, 0);
    idle_a();
    valid_in = 1; alu_result = 24'h000777; reg_dst = 4'd2; reg_we = 1;
    #1;
    chk("post_flush_stall", stall, 0);
    tick();
    chk("post_flush_valid", valid_out, 1);
    chk("post_flush_wb", wb_data_out, 24'h000777);
    chk("post_flush_dst", reg_dst_out, 2);
    idle_a();

    // LAT=0 instance: alternating store/load every cycle.
    for (int i = 0; i < 4; i++) begin
      logic [23:0] v;
      v = 24'h100000 + 24'(i) * 24'h001111;
      b_valid_in = 1; b_mem_we = 1; b_mem_re = 0; b_size_word = 1;
      b_wb_from_mem = 0; b_reg_we = 0; b_alu_result = 24'(32 + i); b_store_data = v;
      #0;
      chk("l0_st_stall", b_stall, 0);
      tick();
      chk("l0_st_valid", b_valid_out, 1);
      b_mem_we = 0; b_mem_re = 1; b_wb_from_mem = 1; b_reg_we = 1; b_reg_dst = 4'(i);
      #0;
      chk("l0_ld_stall", b_stall, 0);
      tick();
      chk("l0_ld_valid", b_valid_out, 1);
      chk("l0_ld_wb", b_wb_data_out, v);
      chk("l0_ld_dst", b_reg_dst_out, 32'(i));
    end
    b_valid_in = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
